// File: rtl/clk_div_cfg_arbiter_if.sv
// Handshake bundle of clk_div_cfg_arbiter: the per-requester change requests
// and the single valid/ready channel towards the clock divider.
interface clk_div_cfg_arbiter_if #(
   parameter int NumReq   = 4,
   parameter int DivWidth = 4
);
   logic [NumReq-1:0]          req_valid_i;
   logic [NumReq*DivWidth-1:0] req_div_i;
   logic [NumReq-1:0]          req_ready_o;
   logic [DivWidth-1:0]        div_o;
   logic                       div_valid_o;
   logic                       div_ready_i;

   modport master (
      output req_valid_i,
      output req_div_i,
      output div_ready_i,
      input  req_ready_o,
      input  div_o,
      input  div_valid_o
   );

   modport slave (
      input  req_valid_i,
      input  req_div_i,
      input  div_ready_i,
      output req_ready_o,
      output div_o,
      output div_valid_o
   );
endinterface

// File: rtl/clk_div_cfg_arbiter.sv
// Round-robin arbiter that forwards divider change requests to a clock divider,
// enforcing a minimum dwell time between two effective divider changes.
module clk_div_cfg_arbiter #(
   parameter int NumReq         = 4,
   parameter int DivWidth       = 4,
   parameter int MinDwellCycles = 16,
   parameter int DefaultDiv     = 0
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   clk_div_cfg_arbiter_if.slave      bus,
   output logic [DivWidth-1:0]       cur_div_o,
   output logic                      busy_o,
   output logic [$clog2(NumReq)-1:0] grant_idx_o
);
   localparam int IdxW  = $clog2(NumReq);
   localparam int IdxW1 = IdxW + 1;
   localparam int CntW  = (MinDwellCycles > 1) ? $clog2(MinDwellCycles) : 1;

   localparam logic [IdxW1-1:0]    NumReqW   = IdxW1'(NumReq);
   localparam logic [CntW-1:0]     DwellLoad = CntW'((MinDwellCycles > 0) ? MinDwellCycles - 1 : 0);
   localparam logic [DivWidth-1:0] DefRaw    = DivWidth'(DefaultDiv);
   localparam logic [DivWidth-1:0] ResetDiv  = (DefRaw == '0) ? DivWidth'(1) : DefRaw;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DWELL = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [IdxW-1:0]     winner_q, winner_d;
   logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
   logic [DivWidth-1:0] div_q, div_d;
   logic [DivWidth-1:0] cur_div_q, cur_div_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic                div_valid_q, div_valid_d;
   logic [NumReq-1:0]   req_ready;
   logic                any_req;
   logic [IdxW-1:0]     pick;
   logic [DivWidth-1:0] req_div_arr [NumReq];

   // A divider of zero is meaningless to the divider, so it is issued as 1.
   function automatic logic [DivWidth-1:0] norm_div(input logic [DivWidth-1:0] v);
      return (v == '0) ? DivWidth'(1) : v;
   endfunction

   function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] idx);
      return (idx == IdxW'(NumReq - 1)) ? '0 : idx + IdxW'(1);
   endfunction

   always_comb begin
      for (int k = 0; k < NumReq; k++) begin
         req_div_arr[k] = bus.req_div_i[k*DivWidth +: DivWidth];
      end
   end

   // Round-robin search starting at rr_ptr_q, wrapping at NumReq.
   always_comb begin
      logic [IdxW1-1:0] cand;
      any_req = 1'b0;
      pick    = rr_ptr_q;
      cand    = '0;
      for (int i = 0; i < NumReq; i++) begin
         cand = {1'b0, rr_ptr_q} + IdxW1'(i);
         if (cand >= NumReqW) begin
            cand = cand - NumReqW;
         end
         if (!any_req && bus.req_valid_i[cand[IdxW-1:0]]) begin
            any_req = 1'b1;
            pick    = cand[IdxW-1:0];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      winner_d  = winner_q;
      div_d     = div_q;
      cur_div_d = cur_div_q;
      rr_ptr_d  = rr_ptr_q;
      cnt_d     = cnt_q;
      req_ready = '0;

      case (state_q)
         IDLE: begin
            if (any_req) begin
               winner_d = pick;
               div_d    = norm_div(req_div_arr[pick]);
               state_d  = ISSUE;
            end
         end
         ISSUE: begin
            if (bus.div_ready_i) begin
               req_ready[winner_q] = 1'b1;
               cur_div_d           = div_q;
               rr_ptr_d            = next_idx(winner_q);
               // Re-issuing the active value does not disturb the clock, so no dwell.
               if ((MinDwellCycles > 0) && (div_q != cur_div_q)) begin
                  cnt_d   = DwellLoad;
                  state_d = DWELL;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         DWELL: begin
            if (cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      div_valid_d = (state_d == ISSUE);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         winner_q    <= '0;
         rr_ptr_q    <= '0;
         div_q       <= ResetDiv;
         cur_div_q   <= ResetDiv;
         cnt_q       <= '0;
         div_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         winner_q    <= winner_d;
         rr_ptr_q    <= rr_ptr_d;
         div_q       <= div_d;
         cur_div_q   <= cur_div_d;
         cnt_q       <= cnt_d;
         div_valid_q <= div_valid_d;
      end
   end

   assign bus.div_o       = div_q;
   assign bus.div_valid_o = div_valid_q;
   assign bus.req_ready_o = req_ready;
   assign cur_div_o       = cur_div_q;
   assign busy_o          = (state_q != IDLE);
   assign grant_idx_o     = winner_q;

   a_issue_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (bus.div_valid_o && !bus.div_ready_i) |=> (bus.div_valid_o && $stable(bus.div_o)));

   a_ready_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
      $onehot0(bus.req_ready_o));
endmodule

// File: doc/clk_div_cfg_arbiter.md
CLK_DIV_CFG_ARBITER -- requirements
Module: clk_div_cfg_arbiter

Interface
REQ-001 SHALL have parameter NumReq, default 4, number of configuration requesters (legal range 2..16).
REQ-002 SHALL have parameter DivWidth, default 4, width of the divider value.
REQ-003 SHALL have parameter MinDwellCycles, default 16, minimum clk_i cycles between two accepted divider changes (0 = no dwell).
REQ-004 SHALL have parameter DefaultDiv, default 0, divider value assumed active after reset.
REQ-005 SHALL have port clk_i, input, 1, clock.
REQ-006 SHALL have port rst_ni, input, 1, reset: asynchronous, active-low.
REQ-007 SHALL have port req_valid_i, input, NumReq, per-requester change request.
REQ-008 SHALL have port req_div_i, input, NumReq*DivWidth, per-requester divider value; requester k uses slice [k*DivWidth +: DivWidth].
REQ-009 SHALL have port req_ready_o, output, NumReq, per-requester accept pulse.
REQ-010 SHALL have port div_o, output, DivWidth, divider value presented to the clock divider.
REQ-011 SHALL have port div_valid_o, output, 1, divider handshake valid.
REQ-012 SHALL have port div_ready_i, input, 1, divider handshake ready.
REQ-013 SHALL have port cur_div_o, output, DivWidth, last accepted divider value, normalized.
REQ-014 SHALL have port busy_o, output, 1, high in any state other than IDLE.
REQ-015 SHALL have port grant_idx_o, output, $clog2(NumReq), index of the currently or last served requester.

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE and DWELL.
REQ-017 IDLE: when any req_valid_i bit is high, SHALL select a winner round-robin, searching from rr_ptr upward with wrap.
REQ-018 On the IDLE grant cycle, SHALL latch the winner index and its req_div_i slice, then go to ISSUE.
REQ-019 Value normalization: SHALL map a latched value of 0 to 1; cur_div_o and div_o always carry the normalized value.
REQ-020 ISSUE: SHALL drive div_valid_o=1 and div_o=latched value, both from registers.
REQ-021 ISSUE: div_valid_o SHALL stay high and div_o stable until div_ready_i=1; div_valid_o SHALL NOT depend combinationally on div_ready_i.
REQ-022 On the ISSUE cycle with div_ready_i=1, SHALL assert req_ready_o[winner]=1 for exactly that cycle (combinational from div_ready_i and state).
REQ-023 On that same cycle, SHALL update cur_div_o on the next edge and set rr_ptr to (winner+1) mod NumReq.
REQ-024 After acceptance, if the latched value differs from the previous cur_div and MinDwellCycles>0, SHALL load the dwell counter with MinDwellCycles-1 and go to DWELL; otherwise go to IDLE.
REQ-025 DWELL: SHALL decrement the counter each cycle, ignore all requests, and go to IDLE on the cycle the counter equals 0.
REQ-026 Dwell length: the next grant SHALL occur no earlier than MinDwellCycles+1 cycles after the accept cycle.
REQ-027 req_ready_o SHALL be 0 outside the ISSUE-accept cycle; at most one bit SHALL be high in any cycle.
REQ-028 Requests held during ISSUE or DWELL SHALL be served afterwards in round-robin order; they are never dropped.
REQ-029 A requester that deasserts req_valid_i after being granted SHALL still have its latched request completed.
REQ-030 Simultaneous requests: SHALL select exactly one winner per IDLE cycle and give the others no partial handshake.
REQ-031 Unreachable encodings SHALL return to IDLE with div_valid_o=0.

Reset
REQ-032 On rst_ni low, SHALL asynchronously enter IDLE.
REQ-033 Reset values: div_valid_o=0, req_ready_o=0, busy_o=0, grant_idx_o=0, rr_ptr=0, dwell counter=0, cur_div_o=div_o=normalized DefaultDiv.
REQ-034 Reset in ISSUE or DWELL SHALL abandon the transaction and emit no req_ready_o pulse.

Verification
REQ-035 Single request: req_valid_i[2]=1 with div 6, div_ready_i returns 3 cycles after div_valid_o rises -> div_o=6 stable throughout; req_ready_o[2] single pulse; cur_div_o=6.
REQ-036 Contention: all four requesters valid, rr_ptr=0, MinDwellCycles=0, immediate ready -> grants in order 0,1,2,3; rr_ptr ends at 0.
REQ-037 Dwell: MinDwellCycles=16, two back-to-back changes 4->8 -> second div_valid_o rises no earlier than 18 cycles after the first accept; same-value request 8->8 -> no DWELL entered.
REQ-038 Normalization: request div 0 with cur_div_o=1 -> div_o=1 issued; no dwell after accept.
REQ-039 Mid-operation reset: assert rst_ni low during ISSUE -> div_valid_o drops immediately; no req_ready_o pulse; cur_div_o=DefaultDiv normalized.
REQ-040 Backpressure: div_ready_i held low for 100 cycles -> div_valid_o and div_o stable; new requests wait; no req_ready_o until div_ready_i goes high.
